// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit (MAR/MDR and SRAM cycle control).
package mau_pkg;

  localparam int WORD_W       = 16;
  localparam int MAU_MAX_WAIT = 15;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mau_state_t;

  // Counter preload for a given wait-state count, clamped into the legal 1..MAU_MAX_WAIT range.
  function automatic logic [CNT_W-1:0] wait_load_value(input int ws);
    int clamped;
    clamped = ws;
    if (clamped < 1) clamped = 1;
    if (clamped > MAU_MAX_WAIT) clamped = MAU_MAX_WAIT;
    return CNT_W'(clamped - 1);
  endfunction

endpackage

// File: rtl/mau_wait_counter.sv
// 4-bit down-counter that times the SRAM strobe window; saturates at zero.
module mau_wait_counter
  import mau_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR registers plus a fixed-wait-state SRAM read/write sequencer.
// Optional sticky protocol-error output is built when MAU_ERR_EN is defined.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int WAIT_STATES = 2
)
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [WORD_W-1:0] DataBus,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              Mem_Req,
  input  logic              Mem_WE,
  input  logic [WORD_W-1:0] Mem_RData,
  output logic [WORD_W-1:0] MAR,
  output logic [WORD_W-1:0] MDR,
  output logic [WORD_W-1:0] Mem_Addr,
  output logic [WORD_W-1:0] Mem_WData,
  output logic              Mem_CE_n,
  output logic              Mem_OE_n,
  output logic              Mem_WE_n,
  output logic              Busy,
  output logic              Done
`ifdef MAU_ERR_EN
  ,
  output logic              Err
`endif
);

  localparam logic [CNT_W-1:0] LOAD_VAL = wait_load_value(WAIT_STATES);

  mau_state_t        state_q, state_d;
  logic [WORD_W-1:0] mar_q, mar_d;
  logic [WORD_W-1:0] mdr_q, mdr_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              is_write_q, is_write_d;
  logic              cnt_load, cnt_dec, cnt_zero;

  mau_wait_counter u_wait_counter (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state and next-output logic; every output below is a register so strobes are glitch-free.
  always_comb begin
    state_d    = state_q;
    mar_d      = mar_q;
    mdr_d      = mdr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    is_write_d = is_write_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        if (LD_MAR) mar_d = DataBus;
        if (LD_MDR) mdr_d = DataBus;
        if (Mem_Req) begin
          is_write_d = Mem_WE;
          addr_d     = LD_MAR ? DataBus : mar_q;
          wdata_d    = LD_MDR ? DataBus : mdr_q;
          cnt_load   = 1'b1;
          state_d    = ACCESS;
          ce_n_d     = 1'b0;
          oe_n_d     = Mem_WE;
          we_n_d     = ~Mem_WE;
          busy_d     = 1'b1;
        end
      end

      ACCESS: begin
        if (cnt_zero) begin
          state_d = DONE;
          done_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          // Writes keep CE asserted one more cycle as address/data hold.
          ce_n_d  = ~is_write_q;
          if (!is_write_q) mdr_d = Mem_RData;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      mar_q      <= '0;
      mdr_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      is_write_q <= is_write_d;
    end
  end

`ifdef MAU_ERR_EN
  logic err_q, err_d;

  // Any control strobe arriving while an access is in flight is a protocol violation; sticky until reset.
  always_comb begin
    err_d = err_q | (busy_q & (LD_MAR | LD_MDR | Mem_Req));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign Err = err_q;
`endif

  assign MAR       = mar_q;
  assign MDR       = mdr_q;
  assign Mem_Addr  = addr_q;
  assign Mem_WData = wdata_q;
  assign Mem_CE_n  = ce_n_q;
  assign Mem_OE_n  = oe_n_q;
  assign Mem_WE_n  = we_n_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access unit holding the MAR and MDR registers of the 16-bit datapath. It loads MAR and MDR from the shared DataBus, drives the registered MDR back as the MDR source of the bus mux, and runs a fixed-wait-state read/write cycle to the external SRAM. Load and request strobes come from the control unit. A one-cycle Done pulse marks completion.

## Interface
- WAIT_STATES, 2: number of cycles the SRAM strobe is held; legal range 1..15
- Clk  in  1  system clock, rising-edge
- Reset_n  in  1  asynchronous, active-low reset
- DataBus  in  16  shared datapath bus
- LD_MAR  in  1  load MAR from DataBus
- LD_MDR  in  1  load MDR from DataBus
- Mem_Req  in  1  start an access; sampled only in IDLE
- Mem_WE  in  1  access type, sampled with Mem_Req; 1 = write, 0 = read
- Mem_RData  in  16  SRAM read data
- MAR  out  16  address register
- MDR  out  16  data register; feeds the bus mux MDR input
- Mem_Addr  out  16  registered SRAM address
- Mem_WData  out  16  registered SRAM write data
- Mem_CE_n, Mem_OE_n, Mem_WE_n  out  1 each  SRAM strobes, active-low, registered
- Busy  out  1  high in ACCESS and DONE
- Done  out  1  one-cycle completion pulse
- Err  out  1  sticky protocol error; present only with MAU_ERR_EN

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - LD_MAR: MAR <= DataBus.
  - LD_MDR: MDR <= DataBus.
  - Mem_Req: latch Mem_WE, set Mem_Addr and Mem_WData, counter <= WAIT_STATES-1, go to ACCESS.
  - Mem_Addr takes DataBus if LD_MAR is high in the same cycle, otherwise MAR.
  - Mem_WData takes DataBus if LD_MDR is high in the same cycle, otherwise MDR.
- **ACCESS**
  - Mem_CE_n=0.
  - Read: Mem_OE_n=0. Write: Mem_WE_n=0.
  - Counter decrements each cycle. When it reaches 0:
    - Read: MDR <= Mem_RData.
    - Both: go to DONE.
- **DONE**
  - Done=1 for this cycle only; next state is IDLE.
  - Read: all strobes high.
  - Write: Mem_CE_n held 0 and Mem_WE_n=1, giving one cycle of address/data hold.
- In ACCESS and DONE, LD_MAR, LD_MDR and Mem_Req are ignored. MAR and MDR change only through the read capture.
- Mem_Addr and Mem_WData stay stable from acceptance through DONE.
- Async reset values, applied at any time:
  - MAR, MDR, Mem_Addr, Mem_WData = 0x0000
  - all strobes = 1
  - Busy, Done, Err = 0
  - state = IDLE
- Reset mid-access aborts the access immediately; no partial MDR update.

## Timing
- Mem_Req accepted at cycle 0.
- Strobes active in cycles 1..WAIT_STATES.
- DONE in cycle WAIT_STATES+1; read data is visible on MDR in that same cycle.
- Next request accepted no earlier than cycle WAIT_STATES+2, so back-to-back spacing is WAIT_STATES+2 cycles.
- Example, WAIT_STATES=2: ACCESS in cycles 1–2, Done in cycle 3, IDLE in cycle 4.
- Mem_RData is sampled on the clock edge ending the last ACCESS cycle; the SRAM must be valid by then.
- Strobe changes are glitch-free because all strobes are register outputs.

## Configuration
- Macro: MAU_ERR_EN.
- Defined:
  - Err port exists.
  - Err sets to 1 on the edge after LD_MAR, LD_MDR or Mem_Req is high while Busy=1.
  - Err clears only on reset.
- Undefined: Err port and its logic are absent; strobes arriving while Busy are silently ignored.

## Structure
- Shared package mau_pkg holds:
  - WORD_W = 16
  - mau_state_t enum {IDLE, ACCESS, DONE}
  - MAU_MAX_WAIT = 15
- One sub-module, mau_wait_counter: a 4-bit down-counter with load, decrement and zero-flag outputs, reset to 0.
- FSM, registers and strobe logic stay in mem_access_unit.

## Test plan
- **Write:** after reset, LD_MAR with DataBus=0x3000, LD_MDR with 0xBEEF, then Mem_Req with Mem_WE=1 -> Mem_Addr=0x3000, Mem_WData=0xBEEF, Mem_WE_n=0 in cycles 1–2, Done=1 with Mem_CE_n=0 and Mem_WE_n=1 in cycle 3.
- **Read:** MAR=0x3001, Mem_RData=0x1234, Mem_Req with Mem_WE=0 -> Mem_OE_n=0 in cycles 1–2, MDR=0x1234 and Done=1 in cycle 3.
- **Same-cycle load:** LD_MAR with DataBus=0x4000 together with a read Mem_Req -> Mem_Addr=0x4000 and MAR=0x4000 from cycle 1.
- **Strobes while busy:** Mem_Req and LD_MDR (DataBus=0xAAAA) in cycle 1 -> ignored, MDR unchanged until the read capture, Err=1 from cycle 2 with MAU_ERR_EN defined.
- **Reset mid-access:** Reset_n low during ACCESS -> all strobes 1, Busy=0 and MDR=0x0000 immediately; a following read completes normally.
- **Minimum wait states:** WAIT_STATES=1 read -> Mem_OE_n=0 in cycle 1 only, Done in cycle 2, a new Mem_Req accepted in cycle 3.
